// File: rtl/rf_pkg.sv
// Shared types and widths for the register-file write-back path.
package rf_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned AW        = 5;
  localparam int unsigned DW        = 32;

  typedef enum logic [1:0] {
    CLEAR,
    RUN,
    DRAIN
  } wb_state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Result-write handshakes, clear control and register-file write port.
interface reg_writeback_ctrl_if;
  import rf_pkg::*;

  logic                 alu_valid;
  logic                 alu_ready;
  logic [AW-1:0]        alu_addr;
  logic [DW-1:0]        alu_data;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [AW-1:0]        ld_addr;
  logic [DW-1:0]        ld_data;
  logic                 clr_req;
  logic                 clr_busy;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [DW-1:0]        wr_data;
  logic [REG_COUNT-1:0] busy;
  logic [7:0]           drop_cnt;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, clr_req,
    input  alu_ready, ld_ready, clr_busy, wr_en, wr_addr, wr_data, busy, drop_cnt
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data, clr_req,
    output alu_ready, ld_ready, clr_busy, wr_en, wr_addr, wr_data, busy, drop_cnt
  );

endinterface

// File: rtl/wb_fifo.sv
// Write-queue FIFO: up to two pushes and one pop per cycle, with an
// occupancy-by-address vector so busy bits survive while a duplicate is queued.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [1:0]                        i_push_n,
  input  wb_entry_t                         i_push0,
  input  wb_entry_t                         i_push1,
  input  logic                              i_pop,
  output logic [$clog2(DEPTH):0]            o_count,
  output wb_entry_t                         o_head_c,
  output logic [REG_COUNT-1:0]              o_occ_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t       r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push_n != 2'd0) r_mem[r_wr_ptr] <= i_push0;
    if (i_push_n == 2'd2) r_mem[PW'(r_wr_ptr + PW'(1))] <= i_push1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= PW'(r_wr_ptr + PW'(i_push_n));
      r_rd_ptr <= PW'(r_rd_ptr + PW'(i_pop));
      r_count  <= CW'(r_count + CW'(i_push_n) - CW'(i_pop));
    end
  end

  // Addresses of all live entries, head included.
  always_comb begin
    o_occ_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) o_occ_c[r_mem[PW'(r_rd_ptr + PW'(i))].addr] = 1'b1;
    end
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_count  = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(r_count) + 32'(i_push_n)) <= 32'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    i_pop |-> (r_count != '0));

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write initiator: queues ALU/load results, issues one write per
// cycle, zero-sweeps r1..r31 after reset or clear, and tracks pending writes.
module reg_writeback_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = rf_pkg::DW,
  parameter int unsigned AW    = rf_pkg::AW
) (
  input  logic                  elk,
  input  logic                  nrst,
  reg_writeback_ctrl_if.slave   bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_state_t            r_state, w_state_nxt;
  logic [AW-1:0]        r_idx, w_idx_nxt;
  logic                 r_wr_en, w_wr_en_nxt;
  logic [AW-1:0]        r_wr_addr, w_wr_addr_nxt;
  logic [DW-1:0]        r_wr_data, w_wr_data_nxt;
  logic [REG_COUNT-1:0] r_busy, w_busy_nxt;
  logic [7:0]           r_drop_cnt, w_drop_nxt;
  logic [8:0]           w_drop_sum;

  logic [CW-1:0]        w_count, w_free;
  wb_entry_t            w_head, w_ld_ent, w_alu_ent, w_push0;
  logic [1:0]           w_push_n;
  logic                 w_pop;
  logic [REG_COUNT-1:0] w_occ, w_set, w_clr;
  logic                 w_ld_ready, w_alu_ready;
  logic                 w_ld_acc, w_alu_acc, w_ld_push, w_alu_push;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (elk),
    .rst_n    (nrst),
    .i_push_n (w_push_n),
    .i_push0  (w_push0),
    .i_push1  (w_alu_ent),
    .i_pop    (w_pop),
    .o_count  (w_count),
    .o_head_c (w_head),
    .o_occ_c  (w_occ)
  );

  assign w_free     = CW'(DEPTH) - w_count;
  assign w_pop      = (w_count != '0);
  assign w_ld_acc   = bus.ld_valid  & w_ld_ready;
  assign w_alu_acc  = bus.alu_valid & w_alu_ready;
  assign w_ld_push  = w_ld_acc  && (bus.ld_addr  != '0);
  assign w_alu_push = w_alu_acc && (bus.alu_addr != '0);

  // Load goes ahead of ALU when both are enqueued together.
  assign w_ld_ent.addr  = bus.ld_addr;
  assign w_ld_ent.data  = bus.ld_data;
  assign w_alu_ent.addr = bus.alu_addr;
  assign w_alu_ent.data = bus.alu_data;
  assign w_push0        = w_ld_push ? w_ld_ent : w_alu_ent;
  assign w_push_n       = 2'(w_ld_push) + 2'(w_alu_push);

  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) r_state <= CLEAR;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = AW'(1);
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_ld_ready    = 1'b0;
    w_alu_ready   = 1'b0;
    unique case (r_state)
      CLEAR: begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_idx;
        w_wr_data_nxt = '0;
        w_idx_nxt     = r_idx + AW'(1);
        if (r_idx == AW'(REG_COUNT - 1)) w_state_nxt = RUN;
      end
      RUN: begin
        w_ld_ready  = (w_free >= CW'(1));
        w_alu_ready = (w_free >= CW'(2)) || ((w_free == CW'(1)) && !bus.ld_valid);
        if (bus.clr_req) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_count == '0) w_state_nxt = CLEAR;
      end
      default: w_state_nxt = CLEAR;
    endcase
    if ((r_state != CLEAR) && w_pop) begin
      w_wr_en_nxt   = 1'b1;
      w_wr_addr_nxt = w_head.addr;
      w_wr_data_nxt = w_head.data;
    end
  end

  // Clear the just-written register unless it is still queued; a new set wins.
  always_comb begin
    w_set = '0;
    if (w_ld_push)  w_set = w_set | (REG_COUNT'(1) << bus.ld_addr);
    if (w_alu_push) w_set = w_set | (REG_COUNT'(1) << bus.alu_addr);
    w_clr = r_wr_en ? (REG_COUNT'(1) << r_wr_addr) : '0;
    if (r_state == CLEAR) w_busy_nxt = '0;
    else w_busy_nxt = ((r_busy & ~(w_clr & ~w_occ)) | w_set) & ~REG_COUNT'(1);
    w_drop_sum = 9'(r_drop_cnt) + 9'(w_ld_acc && !w_ld_push) + 9'(w_alu_acc && !w_alu_push);
    w_drop_nxt = (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
  end

  always_ff @(posedge elk or negedge nrst) begin
    if (!nrst) begin
      r_idx      <= AW'(1);
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_busy     <= w_busy_nxt;
      r_drop_cnt <= w_drop_nxt;
    end
  end

  assign bus.ld_ready  = w_ld_ready;
  assign bus.alu_ready = w_alu_ready;
  assign bus.clr_busy  = (r_state != RUN);
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.busy      = r_busy;
  assign bus.drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench for reg_writeback_ctrl against a queue-level reference model.
module tb_reg_writeback_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef enum {M_SWEEP, M_RUN, M_DRAIN} mode_t;

  logic elk;
  logic nrst;

  reg_writeback_ctrl_if ifc ();

  reg_writeback_ctrl #(.DEPTH(DEPTH)) dut (
    .elk  (elk),
    .nrst (nrst),
    .bus  (ifc.slave)
  );

  initial elk = 1'b0;
  always #5 elk = ~elk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state
  wr_t        mq[$];       // entries accepted but not yet on the write port
  wr_t        exp_wr[$];   // every write the port must still produce, in order
  mode_t      mode;
  int         sweep_left;
  int         m_drop;
  bit         m_wr_en;
  bit         iss_v;
  logic [4:0] iss_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    foreach (mq[i]) b[mq[i].addr] = 1'b1;
    if (iss_v) b[iss_addr] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic start_sweep();
    wr_t w;
    sweep_left = 31;
    for (int a = 1; a < 32; a++) begin
      w.addr = 5'(a);
      w.data = '0;
      exp_wr.push_back(w);
    end
  endtask

  task automatic accept(input logic [4:0] a, input logic [31:0] d);
    wr_t w;
    if (a == 5'd0) begin
      m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
    end else begin
      w.addr = a;
      w.data = d;
      mq.push_back(w);
      exp_wr.push_back(w);
    end
  endtask

  task automatic set_idle();
    ifc.ld_valid  = 1'b0;
    ifc.ld_addr   = '0;
    ifc.ld_data   = '0;
    ifc.alu_valid = 1'b0;
    ifc.alu_addr  = '0;
    ifc.alu_data  = '0;
    ifc.clr_req   = 1'b0;
  endtask

  // One clock of stimulus; called at a falling edge, returns at the next one.
  task automatic cycle(input bit lv, input logic [4:0] la, input logic [31:0] ldd,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit clr);
    int  free, pre;
    bit  e_ld, e_alu;
    wr_t w;
    ifc.ld_valid  = lv;
    ifc.ld_addr   = la;
    ifc.ld_data   = ldd;
    ifc.alu_valid = av;
    ifc.alu_addr  = aa;
    ifc.alu_data  = ad;
    ifc.clr_req   = clr;
    #1;
    free  = DEPTH - mq.size();
    e_ld  = (mode == M_RUN) && (free >= 1);
    e_alu = (mode == M_RUN) && ((free >= 2) || ((free == 1) && !lv));
    check("ld_ready",  ifc.ld_ready,  e_ld);
    check("alu_ready", ifc.alu_ready, e_alu);
    check("wr_en",     ifc.wr_en,     m_wr_en);
    check("busy",      ifc.busy,      model_busy());
    check("drop_cnt",  ifc.drop_cnt,  m_drop);
    check("clr_busy",  ifc.clr_busy,  (mode != M_RUN));
    @(posedge elk);
    pre     = mq.size();
    m_wr_en = 1'b0;
    iss_v   = 1'b0;
    if (mode == M_SWEEP) begin
      m_wr_en = 1'b1;
      sweep_left--;
      if (sweep_left == 0) mode = M_RUN;
    end else begin
      if (pre > 0) begin
        w        = mq.pop_front();
        m_wr_en  = 1'b1;
        iss_v    = 1'b1;
        iss_addr = w.addr;
      end
      if (mode == M_DRAIN && pre == 0) begin
        mode = M_SWEEP;
        start_sweep();
      end else if (mode == M_RUN && clr) begin
        mode = M_DRAIN;
      end
    end
    if (lv && e_ld)  accept(la, ldd);
    if (av && e_alu) accept(aa, ad);
    @(negedge elk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Called at a falling edge; asserts reset mid-cycle and releases it two cycles later.
  task automatic do_reset();
    #2;
    nrst = 1'b0;
    set_idle();
    mq.delete();
    exp_wr.delete();
    m_drop  = 0;
    iss_v   = 1'b0;
    m_wr_en = 1'b0;
    mode    = M_SWEEP;
    start_sweep();
    for (int i = 0; i < 2; i++) begin
      @(negedge elk);
      #1;
      check("rst_wr_en",     ifc.wr_en,     0);
      check("rst_busy",      ifc.busy,      0);
      check("rst_drop_cnt",  ifc.drop_cnt,  0);
      check("rst_clr_busy",  ifc.clr_busy,  1);
      check("rst_ld_ready",  ifc.ld_ready,  0);
      check("rst_alu_ready", ifc.alu_ready, 0);
    end
    @(negedge elk);
    nrst = 1'b1;
  endtask

  // Write-port monitor: every issued write must match the next expected one.
  always @(negedge elk) begin
    wr_t e;
    if (nrst === 1'b1 && ifc.wr_en === 1'b1) begin
      check("wr_expected", (exp_wr.size() != 0), 1);
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        check("wr_addr", ifc.wr_addr, e.addr);
        check("wr_data", ifc.wr_data, e.data);
      end
    end
  end

  initial begin
    nrst = 1'b0;
    set_idle();
    do_reset();
    idle(36);

    // single ALU write
    cycle(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0);
    idle(4);

    // same-cycle load and ALU to one register
    cycle(1, 5'd3, 32'h1, 1, 5'd3, 32'h2, 0);
    idle(5);

    // fill until only the load fits
    for (int i = 0; i < 6; i++)
      cycle(1, 5'(i + 6), 32'(i), 1, 5'(i + 12), 32'(i + 100), 0);
    idle(6);

    // r0 drops: paired first, then a long run to saturation
    for (int i = 0; i < 3; i++) cycle(1, 0, $urandom(), 1, 0, $urandom(), 0);
    for (int i = 0; i < 300; i++) cycle(0, 0, 0, 1, 0, $urandom(), 0);
    idle(3);

    // clear with three entries queued
    cycle(1, 5'd7, 32'hA1, 1, 5'd8, 32'hA2, 0);
    cycle(1, 5'd9, 32'hA3, 1, 5'd10, 32'hA4, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    idle(12);

    // reset in the middle of the sweep
    do_reset();
    idle(40);

    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1), rnd_addr(), $urandom(),
            $urandom_range(0, 1), rnd_addr(), $urandom(),
            ($urandom_range(0, 39) == 0));
    idle(60);

    check("exp_wr_drained", exp_wr.size(), 0);
    check("queue_drained",  mq.size(),     0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
